// File: rtl/if_prefetch_pkg.sv
// Shared definitions for the instruction fetch front end: widths, NOP encoding
// and the buffered fetch entry layout.
package if_prefetch_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [ADDR_W-1:0]  DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with flush; used for both the fetched-entry
// queue and the in-flight PC tag queue.
module if_prefetch_fetch_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    input  logic                   flush,
    output logic [$clog2(DEPTH):0] count,
    output logic [WIDTH-1:0]       head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_q != CW'(DEPTH));
    assign do_pop  = pop && (count_q != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/if_prefetch.sv
// Instruction fetch front end: credit-limited in-order prefetch into a small
// FIFO, with stall via pc_write and redirect that discards stale responses.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               pc_write,
    input  logic               branch_taken,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W-1:0]  pc_plus4,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid
);

    localparam int unsigned    CW  = $clog2(DEPTH) + 1;
    localparam logic [CW:0]    CAP = (CW+1)'(DEPTH);
    localparam int unsigned    EW  = $bits(fetch_entry_t);

    logic [ADDR_W-1:0] fetch_pc_q;
    logic [ADDR_W-1:0] last_pc_q;
    logic              active_q;
    logic [CW-1:0]     drop_cnt_q;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight;
    logic [CW:0]       credit_used;
    logic              req_fire;
    logic              rsp_push;
    logic              head_pop;
    logic [ADDR_W-1:0] tag_head;
    logic [EW-1:0]     entry_raw;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // Buffered plus outstanding fetches never exceed the FIFO capacity, so a
    // returning response always has room.
    assign credit_used    = {1'b0, count} + {1'b0, inflight};
    assign imem_req_valid = active_q && (credit_used < CAP) && !branch_taken;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_push    = imem_rsp_valid && !branch_taken && (drop_cnt_q == '0);
    assign instr_valid = (count != '0);
    assign head_pop    = pc_write && instr_valid && !branch_taken;
    assign push_entry  = '{pc: tag_head, instr: imem_rsp_data};
    assign head_entry  = fetch_entry_t'(entry_raw);

    assign instr    = instr_valid ? head_entry.instr : NOP_INSTR;
    assign pc       = instr_valid ? head_entry.pc : last_pc_q;
    assign pc_plus4 = pc + 32'd4;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            last_pc_q  <= '0;
            active_q   <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            active_q <= 1'b1;
            if (instr_valid) begin
                last_pc_q <= head_entry.pc;
            end
            if (branch_taken) begin
                fetch_pc_q <= branch_target;
                drop_cnt_q <= inflight - CW'(imem_rsp_valid);
            end else begin
                if (req_fire) begin
                    fetch_pc_q <= fetch_pc_q + 32'd4;
                end
                if (imem_rsp_valid && (drop_cnt_q != '0)) begin
                    drop_cnt_q <= drop_cnt_q - CW'(1);
                end
            end
        end
    end

    if_prefetch_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rsp_push),
        .push_data (push_entry),
        .pop       (head_pop),
        .flush     (branch_taken),
        .count     (count),
        .head      (entry_raw)
    );

    // Tag queue occupancy is the in-flight count; stale tags drain with their responses.
    if_prefetch_fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (imem_rsp_valid),
        .flush     (1'b0),
        .count     (inflight),
        .head      (tag_head)
    );

    a_credit : assert property (@(posedge clk) disable iff (!reset) credit_used <= CAP);
    a_drop   : assert property (@(posedge clk) disable iff (!reset) drop_cnt_q <= inflight);

endmodule

// File: tb/tb_if_prefetch.sv
// Directed bench for if_prefetch with an in-order instruction memory model
// of programmable latency.
module tb_if_prefetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        pc_write = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic        instr_valid;

    int checks = 0;
    int failures = 0;
    int mem_lat = 1;
    int edge_n = 0;
    int accepts = 0;
    logic [31:0] last_acc_addr = '0;
    logic [31:0] mq_addr [$];
    int          mq_due [$];

    always #5 clk = ~clk;

    if_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .pc_write       (pc_write),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .instr          (instr),
        .instr_valid    (instr_valid)
    );

    // Memory: record accepts and retire responses on the clock edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mq_addr.delete();
            mq_due.delete();
        end else begin
            if (imem_rsp_valid && mq_addr.size() > 0) begin
                mq_addr.delete(0);
                mq_due.delete(0);
            end
            if (imem_req_valid && imem_req_ready) begin
                mq_addr.push_back(imem_req_addr);
                mq_due.push_back(edge_n + mem_lat);
                accepts++;
                last_acc_addr = imem_req_addr;
            end
            edge_n++;
        end
    end

    // Memory: present the oldest due response for the coming edge.
    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else if (mq_addr.size() > 0 && mq_due[0] <= edge_n) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq_addr[0] ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        int n = 0;
        while (imem_req_valid !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        ok = (imem_req_valid === 1'b1);
    endtask

    task automatic wait_instr(output bit ok);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        ok = (instr_valid === 1'b1);
    endtask

    task automatic test_reset();
        mem_lat = 1;
        imem_req_ready = 1'b1;
        pc_write = 1'b0;
        reset = 1'b0;
        tick();
        tick();
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", imem_req_valid); end
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL reset_instr_valid got=%b exp=0", instr_valid); end
        checks++;
        if (instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=00000000", instr); end
        checks++;
        if (pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=00000000", pc); end
        checks++;
        if (pc_plus4 !== 32'h4) begin failures++; $display("FAIL reset_pc_plus4 got=%h exp=00000004", pc_plus4); end
    endtask

    task automatic test_stream();
        bit ok;
        logic [31:0] ep;
        pc_write = 1'b1;
        reset = 1'b1;
        wait_req(ok);
        checks++;
        if (!ok || imem_req_addr !== 32'h0) begin
            failures++; $display("FAIL stream_first_req valid=%b addr=%h exp valid=1 addr=00000000", imem_req_valid, imem_req_addr);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0) begin failures++; $display("FAIL stream_latency1 got=%b exp=0", instr_valid); end
        tick();
        checks++;
        if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== KEY || pc_plus4 !== 32'h4) begin
            failures++;
            $display("FAIL stream_first_instr valid=%b pc=%h instr=%h pc4=%h exp 1/00000000/%h/00000004", instr_valid, pc, instr, pc_plus4, KEY);
        end
        for (int k = 1; k < 4; k++) begin
            tick();
            ep = 32'(4 * k);
            checks++;
            if (instr_valid !== 1'b1 || pc !== ep || instr !== (ep ^ KEY)) begin
                failures++;
                $display("FAIL stream_seq%0d valid=%b pc=%h instr=%h exp 1/%h/%h", k, instr_valid, pc, instr, ep, ep ^ KEY);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        int a0;
        logic [31:0] ep;
        pc_write = 1'b0;
        do_reset();
        wait_req(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL stall_req_timeout got=%b exp=1", imem_req_valid); end
        a0 = accepts;
        repeat (10) tick();
        checks++;
        if (accepts - a0 != 4) begin failures++; $display("FAIL stall_accepts got=%0d exp=4", accepts - a0); end
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stall_req_valid got=%b exp=0", imem_req_valid); end
        pc_write = 1'b1;
        for (int k = 0; k < 4; k++) begin
            ep = 32'(4 * k);
            checks++;
            if (instr_valid !== 1'b1 || pc !== ep || instr !== (ep ^ KEY)) begin
                failures++;
                $display("FAIL stall_drain%0d valid=%b pc=%h instr=%h exp 1/%h/%h", k, instr_valid, pc, instr, ep, ep ^ KEY);
            end
            tick();
        end
    endtask

    task automatic test_redirect_stale();
        bit ok;
        int a0;
        int a1;
        mem_lat = 3;
        pc_write = 1'b1;
        do_reset();
        wait_req(ok);
        a0 = accepts;
        tick();
        tick();
        checks++;
        if (!ok || accepts - a0 != 2) begin failures++; $display("FAIL stale_setup accepts=%0d exp=2", accepts - a0); end
        branch_taken = 1'b1;
        branch_target = 32'h0000_0100;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL stale_req_in_redirect got=%b exp=0", imem_req_valid); end
        a1 = accepts;
        tick();
        branch_taken = 1'b0;
        checks++;
        if (accepts != a1) begin failures++; $display("FAIL stale_redirect_accept got=%0d exp=%0d", accepts, a1); end
        checks++;
        if (dut.drop_cnt_q !== 3'd2) begin failures++; $display("FAIL stale_drop_cnt got=%0d exp=2", dut.drop_cnt_q); end
        checks++;
        if (imem_req_addr !== 32'h100) begin failures++; $display("FAIL stale_next_addr got=%h exp=00000100", imem_req_addr); end
        wait_instr(ok);
        checks++;
        if (!ok || pc !== 32'h100 || pc_plus4 !== 32'h104 || instr !== (32'h100 ^ KEY)) begin
            failures++;
            $display("FAIL stale_first_instr valid=%b pc=%h pc4=%h instr=%h exp 1/00000100/00000104/%h", instr_valid, pc, pc_plus4, instr, 32'h100 ^ KEY);
        end
    endtask

    task automatic test_redirect_coincident();
        bit ok;
        int a1;
        mem_lat = 2;
        pc_write = 1'b1;
        do_reset();
        wait_req(ok);
        repeat (4) tick();
        @(negedge clk);
        #1;
        checks++;
        if (!ok || imem_rsp_valid !== 1'b1 || instr_valid !== 1'b1 || pc !== 32'h4) begin
            failures++; $display("FAIL coinc_setup rsp=%b valid=%b pc=%h exp 1/1/00000004", imem_rsp_valid, instr_valid, pc);
        end
        branch_taken = 1'b1;
        branch_target = 32'h0000_0200;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0) begin failures++; $display("FAIL coinc_req_in_redirect got=%b exp=0", imem_req_valid); end
        a1 = accepts;
        tick();
        branch_taken = 1'b0;
        #1;
        checks++;
        if (accepts != a1) begin failures++; $display("FAIL coinc_redirect_accept got=%0d exp=%0d", accepts, a1); end
        checks++;
        if (instr_valid !== 1'b0 || instr !== 32'h0) begin failures++; $display("FAIL coinc_flush valid=%b instr=%h exp 0/00000000", instr_valid, instr); end
        checks++;
        if (pc !== 32'h4 || pc_plus4 !== 32'h8) begin failures++; $display("FAIL coinc_pc_hold pc=%h pc4=%h exp 00000004/00000008", pc, pc_plus4); end
        checks++;
        if (dut.drop_cnt_q !== 3'd1) begin failures++; $display("FAIL coinc_drop_cnt got=%0d exp=1", dut.drop_cnt_q); end
        checks++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
            failures++; $display("FAIL coinc_resume valid=%b addr=%h exp 1/00000200", imem_req_valid, imem_req_addr);
        end
        tick();
        checks++;
        if (accepts != a1 + 1 || last_acc_addr !== 32'h200) begin
            failures++; $display("FAIL coinc_accept accepts=%0d addr=%h exp %0d/00000200", accepts, last_acc_addr, a1 + 1);
        end
        wait_instr(ok);
        checks++;
        if (!ok || pc !== 32'h200 || instr !== (32'h200 ^ KEY)) begin
            failures++; $display("FAIL coinc_first_instr valid=%b pc=%h instr=%h exp 1/00000200/%h", instr_valid, pc, instr, 32'h200 ^ KEY);
        end
    endtask

    task automatic test_ready_low();
        bit ok;
        int a0;
        mem_lat = 1;
        pc_write = 1'b1;
        imem_req_ready = 1'b0;
        do_reset();
        wait_req(ok);
        a0 = accepts;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
                failures++; $display("FAIL ready_hold%0d valid=%b addr=%h exp 1/00000000", i, imem_req_valid, imem_req_addr);
            end
            tick();
        end
        checks++;
        if (!ok || accepts != a0) begin failures++; $display("FAIL ready_no_accept got=%0d exp=%0d", accepts, a0); end
        imem_req_ready = 1'b1;
        tick();
        checks++;
        if (accepts != a0 + 1 || last_acc_addr !== 32'h0) begin
            failures++; $display("FAIL ready_accept accepts=%0d addr=%h exp %0d/00000000", accepts, last_acc_addr, a0 + 1);
        end
        checks++;
        if (imem_req_addr !== 32'h4) begin failures++; $display("FAIL ready_advance got=%h exp=00000004", imem_req_addr); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        repeat (3) tick();
        checks++;
        if (instr_valid !== 1'b1) begin failures++; $display("FAIL mid_setup got=%b exp=1", instr_valid); end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            failures++; $display("FAIL mid_valids req=%b instr=%b exp 0/0", imem_req_valid, instr_valid);
        end
        checks++;
        if (instr !== 32'h0 || pc !== 32'h0 || pc_plus4 !== 32'h4) begin
            failures++; $display("FAIL mid_outputs instr=%h pc=%h pc4=%h exp 00000000/00000000/00000004", instr, pc, pc_plus4);
        end
        tick();
        reset = 1'b1;
        wait_req(ok);
        checks++;
        if (!ok || imem_req_addr !== 32'h0) begin
            failures++; $display("FAIL mid_restart valid=%b addr=%h exp 1/00000000", imem_req_valid, imem_req_addr);
        end
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b1 || pc !== 32'h0 || instr !== KEY) begin
            failures++; $display("FAIL mid_first_instr valid=%b pc=%h instr=%h exp 1/00000000/%h", instr_valid, pc, instr, KEY);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect_stale();
        test_redirect_coincident();
        test_ready_low();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
